router_fsm: RTL and testbench
=============================

# router_fsm

Control state machine for the 1x3 router. Watches the incoming byte stream (`pkt_valid`, header address bits), the selected output FIFO's full/empty status and the register block's parity status. Emits the one-hot phase strobes that sequence the register block (`detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`), the FIFO write enable, and `busy` back-pressure to the source.

## Interface
- Parameters: none.
- `clk` in 1: system clock, all state updates on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `pkt_valid` in 1: source byte valid; deasserts on the parity byte.
- `data_in` in 2: header address bits `[1:0]`; 0/1/2 select a FIFO, 3 is invalid.
- `fifo_full` in 1: full flag of the currently selected FIFO.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-FIFO read-timeout soft resets.
- `parity_done` in 1: register block has captured the parity byte.
- `low_pkt_valid` in 1: register block saw `pkt_valid` drop during a load.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` out 1 each: state strobes.
- `write_enb_reg` out 1: write enable to the selected FIFO.
- `busy` out 1: stall request to source.
- `dest_addr` out 2: latched destination of the current packet.

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- `sel_empty` is the `fifo_empty_n` indexed by `dest_addr`.
- `sel_srst` is the `soft_reset_n` indexed by `dest_addr`.
- DECODE_ADDRESS:
  - If `pkt_valid` and `data_in` is not 3: latch `dest_addr <= data_in`.
  - Go to LOAD_FIRST_DATA if that FIFO's empty flag (indexed by `data_in`) is 1, otherwise WAIT_TILL_EMPTY.
  - Address 3, or `pkt_valid`=0: stay; `dest_addr` holds.
- LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
- LOAD_DATA:
  - `fifo_full` → FIFO_FULL_STATE (has priority).
  - Else `!pkt_valid` → LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: `!fifo_full` → LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - `parity_done` → DECODE_ADDRESS.
  - Else `low_pkt_valid` → LOAD_PARITY.
  - Else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: `fifo_full` → FIFO_FULL_STATE; else DECODE_ADDRESS.
- WAIT_TILL_EMPTY: `sel_empty` → LOAD_FIRST_DATA; else stay.
- Soft reset:
  - `sel_srst`=1 in any state other than DECODE_ADDRESS forces next state DECODE_ADDRESS.
  - It overrides all other transitions.
  - Soft resets of non-selected FIFOs are ignored.
- Output decode (Moore, purely from the state register, glitch-free one-hot):
  - `detect_add`=DECODE_ADDRESS, `lfd_state`=LOAD_FIRST_DATA, `ld_state`=LOAD_DATA, `laf_state`=LOAD_AFTER_FULL, `full_state`=FIFO_FULL_STATE, `rst_int_reg`=CHECK_PARITY_ERROR.
  - `write_enb_reg`=1 in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL and LOAD_PARITY.
  - `busy`=1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Reset (`resetn`=0, asynchronous): state=DECODE_ADDRESS, `dest_addr`=0.
  - Outputs during reset: `detect_add`=1; all other strobes, `write_enb_reg` and `busy` are 0.
  - Reset mid-packet abandons the packet immediately, with no write issued after the reset edge.

## Timing
- One state transition per clock; outputs follow the state register, i.e. they reflect input conditions one cycle late.
- Header accepted with empty FIFO:
  - Cycle 0: DECODE sees the header.
  - Cycle 1: `lfd_state`=1, `busy`=1, `write_enb_reg`=1.
  - Cycle 2: `ld_state`=1, `busy`=0.
- Source must hold the current byte while `busy`=1.
- Parity phase: `pkt_valid` low in LOAD_DATA gives LOAD_PARITY on the next cycle, CHECK_PARITY_ERROR the cycle after (`rst_int_reg` high for exactly 1 cycle), then DECODE.
- `fifo_full` in LOAD_DATA gives `full_state` next cycle; `write_enb_reg`=0 for the whole FIFO_FULL_STATE.
- Reset deassertion: first transition possible on the first rising edge with `resetn`=1.
- Back-to-back packets: a header may be presented in the cycle `detect_add` returns to 1.

## Test plan
- Reset, then header 0x05 (addr 1) with `fifo_empty_1`=1 and 3 payload bytes:
  - States DECODE→LFD→LD×3→LP→CPE→DECODE.
  - `dest_addr`=1.
  - `write_enb_reg` high for 5 cycles; `rst_int_reg` high for 1 cycle.
- Header addr 2 with `fifo_empty_2`=0 for 4 cycles:
  - WAIT_TILL_EMPTY with `busy`=1 for 4 cycles.
  - LFD on the cycle after `fifo_empty_2` rises.
- `fifo_full`=1 for 3 cycles mid-payload:
  - FFS held 3 cycles with `write_enb_reg`=0, then LAF, then back to LD with `low_pkt_valid`=0.
  - Repeat with `low_pkt_valid`=1: LAF→LP.
  - Repeat with `parity_done`=1: LAF→DECODE.
- Header with addr bits 3 and `pkt_valid`=1 for 5 cycles: stays in DECODE, `write_enb_reg`=0, `dest_addr` unchanged.
- Packet to addr 0 in LOAD_DATA:
  - Pulse `soft_reset_1` → no effect.
  - Pulse `soft_reset_0` → DECODE next cycle.
- Assert `resetn`=0 asynchronously mid-LOAD_DATA: `detect_add`=1 and `write_enb_reg`=0 before the next clock edge; `dest_addr`=0.

Source files
------------

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: sequences the register block and FIFO writes
// for each packet, and raises busy toward the source while a byte cannot be taken.
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic [1:0] dest_addr,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] dest_addr_q, dest_addr_d;
  logic       hdr_empty;
  logic       sel_empty;
  logic       sel_srst;

  // hdr_empty looks at the incoming header; sel_* look at the latched destination.
  always_comb begin
    hdr_empty = 1'b0;
    sel_empty = 1'b0;
    sel_srst  = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
    case (dest_addr_q)
      2'd0:    begin sel_empty = fifo_empty_0; sel_srst = soft_reset_0; end
      2'd1:    begin sel_empty = fifo_empty_1; sel_srst = soft_reset_1; end
      2'd2:    begin sel_empty = fifo_empty_2; sel_srst = soft_reset_2; end
      default: begin sel_empty = 1'b0;         sel_srst = 1'b0;         end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= DECODE_ADDRESS;
      dest_addr_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      dest_addr_q <= dest_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dest_addr_d = dest_addr_q;
    if (state_q != DECODE_ADDRESS && sel_srst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != 2'd3) begin
            dest_addr_d = data_in;
            state_d     = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (sel_empty) state_d = LOAD_FIRST_DATA;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Source handshake: a byte is consumed on a rising edge where busy=0;
  // while busy=1 the source holds the same byte and pkt_valid unchanged.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state_q)
      DECODE_ADDRESS:     begin detect_add = 1'b1; busy = 1'b0; end
      LOAD_FIRST_DATA:    begin lfd_state = 1'b1; write_enb_reg = 1'b1; end
      LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b0; end
      FIFO_FULL_STATE:    full_state = 1'b1;
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; write_enb_reg = 1'b1; end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default:            ;
    endcase
  end

  assign dest_addr = dest_addr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios then randomized traffic, each
// cycle compared against a phase-name reference model of the routing rules.
module tb_router_fsm;

  logic       clk;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       write_enb_reg;
  logic       busy;
  logic [1:0] dest_addr;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int ri_cnt   = 0;

  string      m_st, m_nx;
  logic [1:0] m_dest, m_dest_nx;

  router_fsm dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy),
    .dest_addr     (dest_addr),
    .state_dbg     (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_next();
    logic [2:0] empt;
    logic [2:0] srst;
    empt      = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srst      = {soft_reset_2, soft_reset_1, soft_reset_0};
    m_nx      = m_st;
    m_dest_nx = m_dest;
    if (m_st == "DA") begin
      if (pkt_valid && data_in != 2'd3) begin
        m_dest_nx = data_in;
        m_nx      = empt[data_in] ? "LFD" : "WTE";
      end
    end else if (srst[m_dest]) m_nx = "DA";
    else if (m_st == "LFD") m_nx = "LD";
    else if (m_st == "LD")  m_nx = fifo_full ? "FFS" : (!pkt_valid ? "LP" : "LD");
    else if (m_st == "FFS") m_nx = fifo_full ? "FFS" : "LAF";
    else if (m_st == "LAF") m_nx = parity_done ? "DA" : (low_pkt_valid ? "LP" : "LD");
    else if (m_st == "LP")  m_nx = "CPE";
    else if (m_st == "CPE") m_nx = fifo_full ? "FFS" : "DA";
    else if (m_st == "WTE") m_nx = empt[m_dest] ? "LFD" : "WTE";
  endtask

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  function automatic logic [7:0] exp_flags(input string st);
    logic w, b;
    w = (st == "LFD") || (st == "LD") || (st == "LAF") || (st == "LP");
    b = !((st == "DA") || (st == "LD"));
    return {st == "DA", st == "LFD", st == "LD", st == "LAF", st == "FFS", st == "CPE", w, b};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h model=%s dbg_state=%0d", tag, obs, exp, m_st, state_dbg);
    end
  endtask

  task automatic check_outputs(input string tag);
    check8({tag, "_flags"},
           {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy},
           exp_flags(m_st));
    check8({tag, "_dest"}, {6'd0, dest_addr}, {6'd0, m_dest});
  endtask

  task automatic step(input string tag);
    model_next();
    @(posedge clk);
    #1;
    if (resetn) begin
      m_st   = m_nx;
      m_dest = m_dest_nx;
    end
    if (write_enb_reg) we_cnt++;
    if (rst_int_reg) ri_cnt++;
    check_outputs(tag);
  endtask

  // Called just after a step (1 time unit past the edge); reset is
  // asserted and released well inside the low/high phases.
  task automatic async_reset(input string tag);
    #2 resetn = 1'b0;
    #1;
    m_st   = "DA";
    m_dest = 2'd0;
    check_outputs(tag);
    #2 resetn = 1'b1;
  endtask

  task automatic idle_inputs();
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    pkt_valid     = 1'b0;
    fifo_full     = 1'b0;
    low_pkt_valid = 1'b0;
    parity_done   = 1'b0;
    for (int i = 0; i < 4; i++) step(tag);
  endtask

  task automatic full_episode(input logic lpv, input logic pd, input string tag);
    pkt_valid = 1'b1;
    data_in   = 2'd1;
    step(tag);
    step(tag);
    step(tag);
    fifo_full = 1'b1;
    we_cnt    = 0;
    for (int i = 0; i < 3; i++) step(tag);
    check8({tag, "_ffs_we_cycles"}, 8'(we_cnt), 8'd0);
    check8({tag, "_in_ffs"}, {7'd0, full_state}, 8'd1);
    fifo_full     = 1'b0;
    low_pkt_valid = lpv;
    parity_done   = pd;
    step(tag);
    check8({tag, "_in_laf"}, {7'd0, laf_state}, 8'd1);
    step(tag);
    drain(tag);
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    m_st   = "DA";
    m_dest = 2'd0;
    #3;
    check_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Packet to addr 1, three payload bytes
    we_cnt    = 0;
    ri_cnt    = 0;
    pkt_valid = 1'b1;
    data_in   = 2'd1;
    step("pkt1");
    check8("pkt1_lfd", {lfd_state, busy, write_enb_reg}, 3'b111);
    step("pkt1");
    check8("pkt1_ld", {ld_state, busy}, 2'b10);
    step("pkt1");
    step("pkt1");
    pkt_valid = 1'b0;
    step("pkt1");
    step("pkt1");
    step("pkt1");
    check8("pkt1_we_cycles", 8'(we_cnt), 8'd5);
    check8("pkt1_rst_int_cycles", 8'(ri_cnt), 8'd1);
    check8("pkt1_dest", {6'd0, dest_addr}, 8'd1);

    // Addr 2 with its FIFO not yet empty
    fifo_empty_2 = 1'b0;
    pkt_valid    = 1'b1;
    data_in      = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step("wte");
      check8("wte_busy", {7'd0, busy}, 8'd1);
    end
    fifo_empty_2 = 1'b1;
    step("wte");
    check8("wte_to_lfd", {7'd0, lfd_state}, 8'd1);
    step("wte");
    drain("wte");

    full_episode(1'b0, 1'b0, "full_ld");
    full_episode(1'b1, 1'b0, "full_lp");
    full_episode(1'b0, 1'b1, "full_da");

    // Invalid address held for five cycles
    pkt_valid = 1'b1;
    data_in   = 2'd3;
    for (int i = 0; i < 5; i++) step("addr3");
    check8("addr3_dest", {6'd0, dest_addr}, 8'd1);

    // Soft resets while loading addr 0
    data_in = 2'd0;
    step("srst");
    step("srst");
    soft_reset_1 = 1'b1;
    step("srst_other");
    check8("srst_other_ld", {7'd0, ld_state}, 8'd1);
    soft_reset_1 = 1'b0;
    soft_reset_0 = 1'b1;
    step("srst_sel");
    check8("srst_sel_da", {7'd0, detect_add}, 8'd1);
    soft_reset_0 = 1'b0;
    pkt_valid    = 1'b0;
    step("srst");

    // Asynchronous reset in the middle of a load
    pkt_valid = 1'b1;
    data_in   = 2'd2;
    step("arst");
    step("arst");
    step("arst");
    async_reset("arst_mid_ld");
    pkt_valid = 1'b0;
    step("arst_after");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 4) == 0);
      fifo_empty_0  = 1'($urandom_range(0, 1));
      fifo_empty_1  = 1'($urandom_range(0, 1));
      fifo_empty_2  = 1'($urandom_range(0, 1));
      soft_reset_0  = ($urandom_range(0, 15) == 0);
      soft_reset_1  = ($urandom_range(0, 15) == 0);
      soft_reset_2  = ($urandom_range(0, 15) == 0);
      parity_done   = ($urandom_range(0, 5) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      step("rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_arst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
